// File: rtl/conv_buf_pkg.sv
// Shared sizing and types for the convolution engine line buffer.
package conv_buf_pkg;
  localparam int BUF_WIDTH = 2;
  localparam int BUF_SIZE  = 4;

  typedef logic [BUF_WIDTH-1:0] buf_addr_t;
  typedef logic [BUF_WIDTH:0]   buf_cnt_t;
endpackage

// File: rtl/ring_buffer_ctrl_if.sv
// Producer/consumer handshake plus buffer strobes for the line buffer controller.
interface ring_buffer_ctrl_if;
  logic wr_valid;
  logic wr_ready;
  logic rd_valid;
  logic rd_ready;
  logic wr_en;
  logic rd_en;

  // Controller side: takes valid/ready requests, issues strobes.
  modport slave (
    input  wr_valid, rd_ready,
    output wr_ready, rd_valid, wr_en, rd_en
  );

  // Producer/consumer side.
  modport master (
    output wr_valid, rd_ready,
    input  wr_ready, rd_valid, wr_en, rd_en
  );
endinterface

// File: rtl/ring_ptr.sv
// Circular pointer with lap bit; the lap flips each time the pointer wraps to 0.
module ring_ptr
  import conv_buf_pkg::*;
#(
  parameter int Width = BUF_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clear,
  input  logic             inc,
  output logic [Width-1:0] ptr,
  output logic             lap
);

  // Reset beats clear beats advance; wrap is the all-ones -> 0 step.
  always_ff @(posedge clk) begin
    if (!rst_n || clear) begin
      ptr <= '0;
      lap <= 1'b0;
    end else if (inc) begin
      ptr <= ptr + Width'(1);
      if (&ptr) lap <= ~lap;
    end
  end

endmodule

// File: rtl/ring_buffer_ctrl.sv
// Sequencing controller for the circular line buffer: owns read/write pointers
// and lap state, converts handshakes into strobes, decodes occupancy status.
module ring_buffer_ctrl
  import conv_buf_pkg::*;
#(
  parameter int BufferWidth = BUF_WIDTH,
  parameter int BufferSize  = BUF_SIZE
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   flush,
  ring_buffer_ctrl_if.slave      bus,
  output logic [BufferWidth-1:0] W_Addr,
  output logic [BufferWidth-1:0] R_Addr,
  output logic                   Round,
  output logic [BufferSize-1:0]  Ready,
  output logic [BufferWidth:0]   count,
  output logic                   full,
  output logic                   empty
);

  // Slot decode relies on the pointers covering every slot exactly once.
  if (BufferSize != 2**BufferWidth) begin : g_bad_size
    $error("ring_buffer_ctrl: BufferSize must equal 2**BufferWidth");
  end

  logic w_lap, r_lap;
  logic same_addr;

  // Handshake: strobes are pure functions of registered status and inputs,
  // so no write-to-read bypass exists within a cycle.
  assign bus.wr_ready = ~full;
  assign bus.rd_valid = ~empty;
  assign bus.wr_en    = bus.wr_valid & bus.wr_ready;
  assign bus.rd_en    = bus.rd_valid & bus.rd_ready;

  // Flush clears both sides; any strobe in the same cycle is dropped by the
  // clear priority inside ring_ptr.
  ring_ptr #(.Width(BufferWidth)) u_wr_ptr (
    .clk   (clk),
    .rst_n (rst_n),
    .clear (flush),
    .inc   (bus.wr_en),
    .ptr   (W_Addr),
    .lap   (w_lap)
  );

  ring_ptr #(.Width(BufferWidth)) u_rd_ptr (
    .clk   (clk),
    .rst_n (rst_n),
    .clear (flush),
    .inc   (bus.rd_en),
    .ptr   (R_Addr),
    .lap   (r_lap)
  );

  // Status decode: equal pointers mean empty on the same lap, full otherwise.
  assign Round     = w_lap ^ r_lap;
  assign same_addr = (W_Addr == R_Addr);
  assign empty     = same_addr & ~Round;
  assign full      = same_addr & Round;
  assign count     = {Round, W_Addr} - {1'b0, R_Addr};

  // Per-slot occupancy: contiguous window [R_Addr, W_Addr) on the same lap,
  // wrapped window when the writer is a lap ahead.
  for (genvar i = 0; i < BufferSize; i++) begin : g_slot
    localparam logic [BufferWidth-1:0] Slot = BufferWidth'(i);
    assign Ready[i] = Round ? ((Slot >= R_Addr) || (Slot < W_Addr))
                            : ((Slot >= R_Addr) && (Slot < W_Addr));
  end

endmodule

// File: tb/tb_ring_buffer_ctrl.sv
// Directed bench for ring_buffer_ctrl. Each status snapshot is packed as
// {W_Addr, R_Addr, Round, Ready, count, empty, full, wr_ready, rd_valid}.
module tb_ring_buffer_ctrl;
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       flush = 1'b0;
  logic [1:0] W_Addr, R_Addr;
  logic       Round;
  logic [3:0] Ready;
  logic [2:0] count;
  logic       full, empty;

  int n_checks = 0;
  int n_fail   = 0;

  localparam logic [15:0] RST_ST = {2'd0, 2'd0, 1'b0, 4'b0000, 3'd0, 1'b1, 1'b0, 1'b1, 1'b0};

  ring_buffer_ctrl_if bus();

  ring_buffer_ctrl #(.BufferWidth(2), .BufferSize(4)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .flush  (flush),
    .bus    (bus),
    .W_Addr (W_Addr),
    .R_Addr (R_Addr),
    .Round  (Round),
    .Ready  (Ready),
    .count  (count),
    .full   (full),
    .empty  (empty)
  );

  always #5 clk = ~clk;

  function automatic logic [15:0] snap();
    return {W_Addr, R_Addr, Round, Ready, count, empty, full, bus.wr_ready, bus.rd_valid};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic wv, input logic rr);
    bus.wr_valid = wv;
    bus.rd_ready = rr;
  endtask

  task automatic test_reset();
    logic [15:0] got;
    rst_n = 1'b0; flush = 1'b0; drive(1'b0, 1'b0);
    step(); step();
    got = snap(); n_checks++;
    if (got !== RST_ST) begin
      n_fail++; $display("FAIL reset_held: got %b expected %b", got, RST_ST);
    end
    rst_n = 1'b1;
    step();
    got = snap(); n_checks++;
    if (got !== RST_ST) begin
      n_fail++; $display("FAIL reset_idle: got %b expected %b", got, RST_ST);
    end
  endtask

  task automatic test_fill();
    logic [15:0] exp_st [4];
    logic [15:0] got;
    exp_st[0] = {2'd1, 2'd0, 1'b0, 4'b0001, 3'd1, 1'b0, 1'b0, 1'b1, 1'b1};
    exp_st[1] = {2'd2, 2'd0, 1'b0, 4'b0011, 3'd2, 1'b0, 1'b0, 1'b1, 1'b1};
    exp_st[2] = {2'd3, 2'd0, 1'b0, 4'b0111, 3'd3, 1'b0, 1'b0, 1'b1, 1'b1};
    exp_st[3] = {2'd0, 2'd0, 1'b1, 4'b1111, 3'd4, 1'b0, 1'b1, 1'b0, 1'b1};
    drive(1'b1, 1'b0);
    for (int k = 0; k < 4; k++) begin
      step();
      got = snap(); n_checks++;
      if (got !== exp_st[k]) begin
        n_fail++; $display("FAIL fill step %0d: got %b expected %b", k, got, exp_st[k]);
      end
    end
    n_checks++;
    if (bus.wr_en !== 1'b0) begin
      n_fail++; $display("FAIL fill_wr_en_when_full: got %b expected 0", bus.wr_en);
    end
    step();
    got = snap(); n_checks++;
    if (got !== exp_st[3]) begin
      n_fail++; $display("FAIL fill_fifth_write: got %b expected %b", got, exp_st[3]);
    end
  endtask

  task automatic test_drain();
    logic [15:0] exp_st [4];
    logic [15:0] got;
    exp_st[0] = {2'd0, 2'd1, 1'b1, 4'b1110, 3'd3, 1'b0, 1'b0, 1'b1, 1'b1};
    exp_st[1] = {2'd0, 2'd2, 1'b1, 4'b1100, 3'd2, 1'b0, 1'b0, 1'b1, 1'b1};
    exp_st[2] = {2'd0, 2'd3, 1'b1, 4'b1000, 3'd1, 1'b0, 1'b0, 1'b1, 1'b1};
    exp_st[3] = {2'd0, 2'd0, 1'b0, 4'b0000, 3'd0, 1'b1, 1'b0, 1'b1, 1'b0};
    drive(1'b0, 1'b1);
    for (int k = 0; k < 4; k++) begin
      step();
      got = snap(); n_checks++;
      if (got !== exp_st[k]) begin
        n_fail++; $display("FAIL drain step %0d: got %b expected %b", k, got, exp_st[k]);
      end
    end
    n_checks++;
    if (bus.rd_en !== 1'b0) begin
      n_fail++; $display("FAIL drain_rd_en_when_empty: got %b expected 0", bus.rd_en);
    end
    step();
    got = snap(); n_checks++;
    if (got !== exp_st[3]) begin
      n_fail++; $display("FAIL drain_extra_read: got %b expected %b", got, exp_st[3]);
    end
  endtask

  // Starts at W=0,R=0 with both laps set: write 3, read 2, write 2.
  task automatic test_wrap();
    logic [15:0] exp_a, exp_b, exp_c, got;
    exp_a = {2'd3, 2'd0, 1'b0, 4'b0111, 3'd3, 1'b0, 1'b0, 1'b1, 1'b1};
    exp_b = {2'd3, 2'd2, 1'b0, 4'b0100, 3'd1, 1'b0, 1'b0, 1'b1, 1'b1};
    exp_c = {2'd1, 2'd2, 1'b1, 4'b1101, 3'd3, 1'b0, 1'b0, 1'b1, 1'b1};
    drive(1'b1, 1'b0); repeat (3) step();
    got = snap(); n_checks++;
    if (got !== exp_a) begin
      n_fail++; $display("FAIL wrap_write3: got %b expected %b", got, exp_a);
    end
    drive(1'b0, 1'b1); repeat (2) step();
    got = snap(); n_checks++;
    if (got !== exp_b) begin
      n_fail++; $display("FAIL wrap_read2: got %b expected %b", got, exp_b);
    end
    drive(1'b1, 1'b0); repeat (2) step();
    got = snap(); n_checks++;
    if (got !== exp_c) begin
      n_fail++; $display("FAIL wrap_write2: got %b expected %b", got, exp_c);
    end
  endtask

  // From W=1,R=2,Round=1: one read brings count to 2, then 6 paired fires.
  task automatic test_back_to_back();
    logic [15:0] exp_st [6];
    logic [15:0] exp_pre, got;
    exp_pre   = {2'd1, 2'd3, 1'b1, 4'b1001, 3'd2, 1'b0, 1'b0, 1'b1, 1'b1};
    exp_st[0] = {2'd2, 2'd0, 1'b0, 4'b0011, 3'd2, 1'b0, 1'b0, 1'b1, 1'b1};
    exp_st[1] = {2'd3, 2'd1, 1'b0, 4'b0110, 3'd2, 1'b0, 1'b0, 1'b1, 1'b1};
    exp_st[2] = {2'd0, 2'd2, 1'b1, 4'b1100, 3'd2, 1'b0, 1'b0, 1'b1, 1'b1};
    exp_st[3] = {2'd1, 2'd3, 1'b1, 4'b1001, 3'd2, 1'b0, 1'b0, 1'b1, 1'b1};
    exp_st[4] = {2'd2, 2'd0, 1'b0, 4'b0011, 3'd2, 1'b0, 1'b0, 1'b1, 1'b1};
    exp_st[5] = {2'd3, 2'd1, 1'b0, 4'b0110, 3'd2, 1'b0, 1'b0, 1'b1, 1'b1};
    drive(1'b0, 1'b1); step();
    got = snap(); n_checks++;
    if (got !== exp_pre) begin
      n_fail++; $display("FAIL b2b_setup: got %b expected %b", got, exp_pre);
    end
    drive(1'b1, 1'b1);
    for (int k = 0; k < 6; k++) begin
      step();
      got = snap(); n_checks++;
      if (got !== exp_st[k]) begin
        n_fail++; $display("FAIL b2b step %0d: got %b expected %b", k, got, exp_st[k]);
      end
    end
  endtask

  // From W=3,R=1 (count 2): one write gives count 3, then flush with both fires.
  task automatic test_flush();
    logic [15:0] exp_pre, exp_w3, got;
    exp_pre = {2'd0, 2'd1, 1'b1, 4'b1110, 3'd3, 1'b0, 1'b0, 1'b1, 1'b1};
    exp_w3  = {2'd3, 2'd0, 1'b0, 4'b0111, 3'd3, 1'b0, 1'b0, 1'b1, 1'b1};
    drive(1'b1, 1'b0); step();
    got = snap(); n_checks++;
    if (got !== exp_pre) begin
      n_fail++; $display("FAIL flush_setup: got %b expected %b", got, exp_pre);
    end
    drive(1'b1, 1'b1); flush = 1'b1; step();
    flush = 1'b0; drive(1'b0, 1'b0);
    got = snap(); n_checks++;
    if (got !== RST_ST) begin
      n_fail++; $display("FAIL flush_clear: got %b expected %b", got, RST_ST);
    end
    drive(1'b1, 1'b0); repeat (3) step();
    got = snap(); n_checks++;
    if (got !== exp_w3) begin
      n_fail++; $display("FAIL flush_refill: got %b expected %b", got, exp_w3);
    end
    drive(1'b1, 1'b1); flush = 1'b1; rst_n = 1'b0; step();
    flush = 1'b0; rst_n = 1'b1; drive(1'b0, 1'b0);
    got = snap(); n_checks++;
    if (got !== RST_ST) begin
      n_fail++; $display("FAIL flush_with_reset: got %b expected %b", got, RST_ST);
    end
  endtask

  // Boundaries: read at full frees a slot with write held off; read at empty ignored.
  task automatic test_boundaries();
    logic [15:0] exp_full, exp_after, exp_empty_wr, got;
    exp_full     = {2'd0, 2'd0, 1'b1, 4'b1111, 3'd4, 1'b0, 1'b1, 1'b0, 1'b1};
    exp_after    = {2'd0, 2'd1, 1'b1, 4'b1110, 3'd3, 1'b0, 1'b0, 1'b1, 1'b1};
    exp_empty_wr = {2'd1, 2'd0, 1'b0, 4'b0001, 3'd1, 1'b0, 1'b0, 1'b1, 1'b1};
    drive(1'b1, 1'b0); repeat (4) step();
    got = snap(); n_checks++;
    if (got !== exp_full) begin
      n_fail++; $display("FAIL bound_full: got %b expected %b", got, exp_full);
    end
    drive(1'b1, 1'b1); step();
    got = snap(); n_checks++;
    if (got !== exp_after) begin
      n_fail++; $display("FAIL bound_read_at_full: got %b expected %b", got, exp_after);
    end
    n_checks++;
    if (bus.wr_en !== 1'b1) begin
      n_fail++; $display("FAIL bound_wr_en_after_free: got %b expected 1", bus.wr_en);
    end
    drive(1'b0, 1'b0); flush = 1'b1; step(); flush = 1'b0;
    drive(1'b1, 1'b1); step();
    drive(1'b0, 1'b0);
    got = snap(); n_checks++;
    if (got !== exp_empty_wr) begin
      n_fail++; $display("FAIL bound_write_at_empty: got %b expected %b", got, exp_empty_wr);
    end
  endtask

  initial begin
    bus.wr_valid = 1'b0;
    bus.rd_ready = 1'b0;
    test_reset();
    test_fill();
    test_drain();
    test_wrap();
    test_back_to_back();
    test_flush();
    test_boundaries();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/ring_buffer_ctrl.md
Name: ring_buffer_ctrl

Overview:
Sequencing controller for the 4-slot circular line buffer in the convolution engine.
- Owns the write pointer, read pointer and lap ("Round") state.
- Converts producer and consumer valid/ready handshakes into buffer write and read strobes.
- Publishes per-slot ready flags, occupancy, and full/empty status to the MAC datapath.

Parameters:
BufferWidth, 2, pointer width in bits.
BufferSize, 4, number of slots; must equal 2**BufferWidth (elaboration-time check).

Ports:
clk  input  1  single system clock, rising edge
rst_n  input  1  synchronous active-low reset
flush  input  1  synchronous clear of pointers and state; data in the buffer is discarded
wr_valid  input  1  producer has a word
wr_ready  output  1  controller accepts a word (= !full)
rd_valid  output  1  word available at R_Addr (= !empty)
rd_ready  input  1  consumer takes the word
wr_en  output  1  buffer write strobe (= wr_valid & wr_ready)
rd_en  output  1  buffer read-advance strobe (= rd_valid & rd_ready)
W_Addr  output  BufferWidth  next slot to write
R_Addr  output  BufferWidth  next slot to read
Round  output  1  writer is one lap ahead of reader (w_lap ^ r_lap)
Ready  output  BufferSize  bit i = slot i holds unread data
count  output  BufferWidth+1  occupancy, 0..BufferSize
full  output  1  count == BufferSize
empty  output  1  count == 0

Behaviour:
- All state updates on the rising clk edge.
- Reset: when rst_n=0 at an edge, W_Addr=0, R_Addr=0, w_lap=0, r_lap=0.
  - Outputs after reset: Round=0, Ready=0, count=0, empty=1, full=0, wr_ready=1, rd_valid=0.
- Priority: rst_n over flush over handshakes.
- flush=1 has the same effect as reset for one cycle; strobes issued in that cycle are ignored.
- Write fire (wr_en=1):
  - W_Addr increments by 1.
  - On wrap from BufferSize-1 to 0, w_lap toggles.
- Read fire (rd_en=1):
  - R_Addr increments by 1.
  - On wrap, r_lap toggles.
- Registered state: W_Addr, R_Addr, w_lap, r_lap only. Everything else is combinational from that state.
- Status decode:
  - Round = w_lap ^ r_lap.
  - empty = (W_Addr==R_Addr) & !Round.
  - full = (W_Addr==R_Addr) & Round.
  - count = {Round,W_Addr} - {0,R_Addr}, computed in BufferWidth+1 bits; equals BufferSize when full.
- Ready[i]:
  - Round=0: R_Addr <= i < W_Addr.
  - Round=1: i >= R_Addr or i < W_Addr.
  - full gives all ones; empty gives all zeros.
- Latency:
  - A write fired in cycle n makes Ready[W_Addr_n] and rd_valid visible in cycle n+1.
  - No write-to-read bypass in the same cycle.
- Simultaneous write and read fire: both pointers advance and count is unchanged.
- Full: wr_ready=0, so wr_valid is held off. A read in that cycle frees a slot; wr_ready rises in the next cycle.
- Empty: rd_valid=0, so rd_ready is ignored. A write in that cycle makes rd_valid=1 in the next cycle.
- Handshake rule: the producer must hold wr_valid and data until wr_ready. The controller never drops an accepted word.
- Ready, full and empty are glitch-free relative to clk because they derive only from registers.

Decomposition:
- Shared package conv_buf_pkg:
  - BUF_WIDTH=2, BUF_SIZE=4.
  - typedef buf_addr_t [BUF_WIDTH-1:0].
  - typedef buf_cnt_t [BUF_WIDTH:0].
- One sub-module, ring_ptr: pointer register plus lap bit, with inc, clear, wrap toggle and synchronous active-low reset. Instantiated twice, for the write side and the read side.
- Status and Ready decode stay in the top level.

Test Plan:
1. Reset then idle: rst_n=0 for 2 cycles, then 1 -> W_Addr=0, R_Addr=0, Round=0, Ready=4'b0000, count=0, empty=1, wr_ready=1, rd_valid=0.
2. Fill: wr_valid=1 for 4 cycles, rd_ready=0 -> W_Addr 1,2,3,0; Ready 0001,0011,0111,1111; Round=1, full=1, count=4, wr_ready=0. A 5th write is not accepted and W_Addr stays 0.
3. Drain after fill: rd_ready=1 for 4 cycles -> R_Addr 1,2,3,0; Ready 1110,1100,1000,0000; Round=0, empty=1, rd_valid=0 afterward.
4. Wrap with lap: write 3, read 2, then write 2 -> W_Addr=1, R_Addr=2, Round=1, count=3, Ready=4'b1101.
5. Simultaneous write and read at count=2 for 6 cycles -> count stays 2 every cycle, both pointers advance 6 (mod 4), and Round toggles consistently.
6. Flush mid-operation at count=3 with wr_valid=1 and rd_ready=1 -> next cycle all state is at reset values with no pointer advance. Repeat with rst_n=0 asserted together with flush: same result.
